// File: rtl/cmac_job_sequencer.sv
// cmac_job_sequencer
// Job-level controller wrapped around the AES_CMAC core and its shared 128-bit
// message BRAM. The host hands over (base, bit length) jobs. Each job is range
// checked, the core is put through a reset/run cycle, the core's zero-based
// BRAM addresses are offset by the job base, and the captured tag is returned.
// This lets several messages share one BRAM image and be tagged back-to-back.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   job_valid/job_ready         host job handshake (ready only while idle)
//   job_base, job_len           first BRAM word and message length in bits
//   core_reset, core_len        drive the AES_CMAC reset and len inputs
//   core_messAddra/cmacAddra    zero-based read addresses from the core
//   core_cmacDone, core_tag     core completion level and tag
//   ram_messAddra/cmacAddra     relocated BRAM addresses (base + core address)
//   tag_valid/tag_ready         result handshake
//   tag_out, tag_base, err      result tag, owning job base, reject/timeout flag
//   busy                        high whenever a job is in flight
module cmac_job_sequencer #(
    parameter int ADDR_W     = 9,
    parameter int DEPTH      = 512,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_base,
    input  logic [31:0]       job_len,
    output logic              core_reset,
    output logic [31:0]       core_len,
    input  logic [ADDR_W-1:0] core_messAddra,
    input  logic [ADDR_W-1:0] core_cmacAddra,
    input  logic              core_cmacDone,
    input  logic [127:0]      core_tag,
    output logic [ADDR_W-1:0] ram_messAddra,
    output logic [ADDR_W-1:0] ram_cmacAddra,
    output logic              tag_valid,
    input  logic              tag_ready,
    output logic [127:0]      tag_out,
    output logic [ADDR_W-1:0] tag_base,
    output logic              err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CORE_RST,
        S_RUN,
        S_RESP
    } state_t;

    // One counter serves both the core reset hold and the run timeout, so it
    // must be wide enough for the larger of the two limits.
    localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SPAN_W  = ADDR_W + 33;
    localparam logic [SPAN_W-1:0] DEPTH_EXT = SPAN_W'(DEPTH);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   base_q;
    logic [31:0]         len_q;
    logic [127:0]        tag_q;
    logic                err_q;
    logic [32:0]         words;
    logic [SPAN_W-1:0]   span;
    logic                check_fail;
    logic                rst_done;
    logic                timed_out;

    // The word count is formed in 33 bits so a length close to 2**32 cannot
    // wrap to a small count, and the end-of-message address is compared at
    // full width so an oversized job is rejected rather than wrapping around.
    assign words      = ({1'b0, len_q} + 33'd127) >> 7;
    assign span       = {33'd0, base_q} + {{ADDR_W{1'b0}}, words};
    assign check_fail = (len_q == 32'd0) || (span > DEPTH_EXT);
    assign rst_done   = (cnt == CNT_W'(RST_CYCLES - 1));
    assign timed_out  = (cnt == CNT_W'(TIMEOUT));

    // State register; reset drops straight back to idle, which also raises
    // core_reset immediately because that output decodes from the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In RUN the timeout test comes first so that a done
    // arriving on the very cycle the limit is hit still reports a timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (job_valid) state_next = S_CHECK;
            S_CHECK:    state_next = check_fail ? S_RESP : S_CORE_RST;
            S_CORE_RST: if (rst_done) state_next = S_RUN;
            S_RUN:      if (timed_out || core_cmacDone) state_next = S_RESP;
            S_RESP:     if (tag_ready) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Moore outputs. The core is held in reset in every state except RUN,
    // which is why a stale done level outside RUN has no effect.
    always_comb begin
        job_ready  = 1'b0;
        busy       = 1'b1;
        core_reset = 1'b1;
        tag_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RUN:   core_reset = 1'b0;
            S_RESP:  tag_valid  = 1'b1;
            default: ;
        endcase
    end

    // Cycle counter: counts the cycles spent in CORE_RST or RUN and restarts
    // from zero on every state change, so RUN always begins with a count of 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if ((state == S_CORE_RST || state == S_RUN) && (state_next == state)) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Job and result registers. The job is latched on acceptance; the result
    // is written only when leaving CHECK with an error or when leaving RUN,
    // so it stays frozen for the whole response handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
            tag_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        base_q <= job_base;
                        len_q  <= job_len;
                    end
                end
                S_CHECK: begin
                    if (check_fail) begin
                        tag_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (timed_out) begin
                        tag_q <= '0;
                        err_q <= 1'b1;
                    end else if (core_cmacDone) begin
                        tag_q <= core_tag;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Relocation is a plain modular add; accepted jobs never wrap thanks to
    // the range check.
    assign ram_messAddra = base_q + core_messAddra;
    assign ram_cmacAddra = base_q + core_cmacAddra;
    assign core_len      = len_q;
    assign tag_out       = tag_q;
    assign tag_base      = base_q;
    assign err           = err_q;

endmodule

// File: tb/tb_cmac_job_sequencer.sv
// tb_cmac_job_sequencer
// Self-checking bench for cmac_job_sequencer. A small behavioural stand-in for
// the AES_CMAC core answers the sequencer, a job-level reference model predicts
// every output on every cycle, and a set of directed jobs pins the model with
// hand-computed latencies and results.
module tb_cmac_job_sequencer;

    localparam int ADDR_W     = 9;
    localparam int DEPTH      = 512;
    localparam int RST_CYCLES = 4;
    localparam int TIMEOUT    = 50;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [ADDR_W-1:0] job_base = '0;
    logic [31:0]       job_len = '0;
    logic              core_reset;
    logic [31:0]       core_len;
    logic [ADDR_W-1:0] core_messAddra = '0;
    logic [ADDR_W-1:0] core_cmacAddra = '0;
    logic              core_cmacDone = 1'b0;
    logic [127:0]      core_tag;
    logic [ADDR_W-1:0] ram_messAddra;
    logic [ADDR_W-1:0] ram_cmacAddra;
    logic              tag_valid;
    logic              tag_ready = 1'b0;
    logic [127:0]      tag_out;
    logic [ADDR_W-1:0] tag_base;
    logic              err;
    logic              busy;

    int nTotal = 0;
    int nBad = 0;
    int cyc = 0;

    int           stimLat = 0;
    logic [127:0] stimTag = '0;

    bit                mdlBusy = 1'b0;
    bit                jobBad = 1'b0;
    bit                jobErr = 1'b0;
    int                jobLat = 1000;
    logic [127:0]      jobTag = '0;
    logic [ADDR_W-1:0] jobBase = '0;
    logic [ADDR_W-1:0] lastBase = '0;
    logic [31:0]       lastLen = '0;
    int                runCyc = 0;
    int                respCyc = 0;
    int                runK = 0;

    assign core_tag = jobTag;

    cmac_job_sequencer #(
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .RST_CYCLES(RST_CYCLES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_base(job_base),
        .job_len(job_len),
        .core_reset(core_reset),
        .core_len(core_len),
        .core_messAddra(core_messAddra),
        .core_cmacAddra(core_cmacAddra),
        .core_cmacDone(core_cmacDone),
        .core_tag(core_tag),
        .ram_messAddra(ram_messAddra),
        .ram_cmacAddra(ram_cmacAddra),
        .tag_valid(tag_valid),
        .tag_ready(tag_ready),
        .tag_out(tag_out),
        .tag_base(tag_base),
        .err(err),
        .busy(busy)
    );

    // Free-running clock and a cycle index shared by model and directed tests.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nTotal++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Stand-in for the AES_CMAC core: random read addresses every cycle, a
    // random done level while held in reset (which must be ignored), and once
    // released a done level that rises after jobLat cycles of running.
    always @(posedge clk) begin
        #1;
        core_messAddra = ADDR_W'($urandom);
        core_cmacAddra = ADDR_W'($urandom);
        if (core_reset) begin
            runK = 0;
            core_cmacDone = 1'($urandom);
        end else begin
            core_cmacDone = (runK >= jobLat);
            runK++;
        end
    end

    // Job-level reference model, evaluated mid-cycle. It knows only the job
    // timeline: accept at cycle A, check at A+1, core released at
    // A+2+RST_CYCLES, result one cycle after done (or after TIMEOUT+1 run
    // cycles), or at A+2 for a rejected job. It first checks the outputs for
    // the current cycle, then applies this cycle's handshakes.
    always @(negedge clk) begin
        longint words;
        bit     expTv;
        bit     expCr;
        if (reset) begin
            checkOutput("rst_job_ready", job_ready, 1);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_tag_valid", tag_valid, 0);
            checkOutput("rst_core_reset", core_reset, 1);
            checkOutput("rst_core_len", core_len, 0);
            checkOutput("rst_tag_out", tag_out, 0);
            checkOutput("rst_tag_base", tag_base, 0);
            checkOutput("rst_err", err, 0);
            mdlBusy  = 1'b0;
            lastBase = '0;
            lastLen  = '0;
        end else begin
            expTv = mdlBusy && (cyc >= respCyc);
            expCr = !(mdlBusy && !jobBad && (cyc >= runCyc) && (cyc < respCyc));
            checkOutput("job_ready", job_ready, !mdlBusy);
            checkOutput("busy", busy, mdlBusy);
            checkOutput("tag_valid", tag_valid, expTv);
            checkOutput("core_reset", core_reset, expCr);
            checkOutput("core_len", core_len, lastLen);
            checkOutput("ram_messAddra", ram_messAddra,
                        (int'(lastBase) + int'(core_messAddra)) % (1 << ADDR_W));
            checkOutput("ram_cmacAddra", ram_cmacAddra,
                        (int'(lastBase) + int'(core_cmacAddra)) % (1 << ADDR_W));
            if (expTv) begin
                checkOutput("err", err, jobErr);
                checkOutput("tag_out", tag_out, jobErr ? 128'd0 : jobTag);
                checkOutput("tag_base", tag_base, jobBase);
            end
            if (mdlBusy) begin
                if (expTv && tag_ready) mdlBusy = 1'b0;
            end else if (job_valid) begin
                words    = (longint'(job_len) + 127) / 128;
                jobBad   = (job_len == 0) || (longint'(job_base) + words > DEPTH);
                jobLat   = stimLat;
                jobTag   = stimTag;
                jobBase  = job_base;
                lastBase = job_base;
                lastLen  = job_len;
                runCyc   = cyc + 2 + RST_CYCLES;
                if (jobBad) begin
                    respCyc = cyc + 2;
                    jobErr  = 1'b1;
                end else if (stimLat < TIMEOUT) begin
                    respCyc = runCyc + stimLat + 1;
                    jobErr  = 1'b0;
                end else begin
                    respCyc = runCyc + TIMEOUT + 1;
                    jobErr  = 1'b1;
                end
                mdlBusy = 1'b1;
            end
        end
    end

    // Waits (bounded) until the model is idle, so a directed job is accepted
    // on the cycle it is presented.
    task automatic waitIdle();
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        while (mdlBusy && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (mdlBusy) checkOutput("wait_idle_bound", 1, 0);
    endtask

    // Runs one directed job and checks hand-computed literals: cycles from
    // acceptance to core release and to tag_valid, the result, and optionally
    // a stretch of back-pressure during which a second job is offered.
    task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [31:0] l, input int lat,
                                 input logic [127:0] tg, input int hold, input int expOff,
                                 input int expFall, input bit expErr);
        int t0;
        int fall;
        int respOff;
        waitIdle();
        tag_ready = 1'b0;
        stimLat   = lat;
        stimTag   = tg;
        job_base  = b;
        job_len   = l;
        job_valid = 1'b1;
        t0 = cyc;
        fall = -1;
        respOff = -1;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            if (fall < 0 && !core_reset) fall = cyc - t0;
            if (tag_valid) begin
                respOff = cyc - t0;
                break;
            end
        end
        checkOutput("lit_resp_offset", respOff, expOff);
        checkOutput("lit_fall_offset", fall, expFall);
        checkOutput("lit_err", err, expErr);
        checkOutput("lit_tag", tag_out, expErr ? 128'd0 : tg);
        checkOutput("lit_tag_base", tag_base, b);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            job_valid = 1'b1;
            job_base  = 9'd1;
            job_len   = 32'd128;
            @(negedge clk);
            checkOutput("bp_job_ready", job_ready, 0);
            checkOutput("bp_tag_valid", tag_valid, 1);
            checkOutput("bp_tag", tag_out, expErr ? 128'd0 : tg);
        end
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        tag_ready = 1'b1;
        @(posedge clk);
        #1;
        tag_ready = 1'b0;
        @(negedge clk);
        checkOutput("lit_tv_after_hs", tag_valid, 0);
    endtask

    // Main sequence: reset, a long randomized phase, then directed jobs
    // covering range boundaries, timeout, back-pressure and mid-job reset.
    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            job_valid = ($urandom % 3) == 0;
            job_base  = (($urandom % 4) == 0) ? ADDR_W'(DEPTH - 1 - $urandom_range(0, 20))
                                              : ADDR_W'($urandom_range(0, DEPTH - 1));
            case ($urandom % 8)
                0:       job_len = 32'd0;
                1:       job_len = $urandom;
                default: job_len = $urandom_range(1, 3000);
            endcase
            stimLat   = (($urandom % 5) == 0) ? $urandom_range(45, 200) : $urandom_range(0, 40);
            stimTag   = {$urandom, $urandom, $urandom, $urandom};
            tag_ready = ($urandom % 4) != 0;
        end

        @(posedge clk);
        #1;
        job_valid = 1'b0;
        tag_ready = 1'b1;
        guard = 0;
        while (mdlBusy && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (mdlBusy) checkOutput("drain_bound", 1, 0);
        tag_ready = 1'b0;

        applyStimulus(9'd500, 32'd2048, 5, 128'h1111, 0, 2, -1, 1'b1);
        applyStimulus(9'd0, 32'd0, 5, 128'h2222, 0, 2, -1, 1'b1);
        applyStimulus(9'd0, 32'd128, 3, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 0, 10, 6, 1'b0);
        applyStimulus(9'd510, 32'd256, 0, 128'hcafe_0001, 0, 7, 6, 1'b0);
        applyStimulus(9'd511, 32'd257, 0, 128'h3333, 0, 2, -1, 1'b1);
        applyStimulus(9'd0, 32'hFFFF_FF81, 0, 128'h4444, 0, 2, -1, 1'b1);
        applyStimulus(9'd0, 32'd34176, 20, 128'hdead_beef_0000_0000_1234_5678_9abc_def0, 0, 27, 6, 1'b0);
        applyStimulus(9'd300, 32'd256, 7, 128'h5555_aaaa, 10, 14, 6, 1'b0);
        applyStimulus(9'd300, 32'd256, 1000, 128'h6666, 0, 57, 6, 1'b1);
        applyStimulus(9'd100, 32'd128, 49, 128'h7777, 0, 56, 6, 1'b0);
        applyStimulus(9'd100, 32'd128, 50, 128'h8888, 0, 57, 6, 1'b1);

        waitIdle();
        stimLat   = 1000;
        stimTag   = 128'h9999;
        job_base  = 9'd200;
        job_len   = 32'd512;
        job_valid = 1'b1;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        guard = 0;
        while (core_reset && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("lit_reached_run", core_reset, 0);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("lit_async_core_reset", core_reset, 1);
        checkOutput("lit_async_busy", busy, 0);
        checkOutput("lit_async_job_ready", job_ready, 1);
        checkOutput("lit_async_core_len", core_len, 0);
        checkOutput("lit_async_tag_valid", tag_valid, 0);
        checkOutput("lit_async_ram_mess", ram_messAddra, core_messAddra);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;

        applyStimulus(9'd2, 32'd300, 5, 128'habcd_ef01, 0, 12, 6, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

    // Hard stop in case a bounded wait is ever miscounted.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, bad=%0d", nBad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
